mac_sched: RTL and testbench
============================

MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 The block SHALL have parameter size, default 8, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester N presents an operation.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: requester N operation accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req0_c, req1_a, req1_b and req1_c, input, size bits each: unsigned operands A, B and C per requester.
REQ-007 The block SHALL have port res_valid, output, 1 bit: result held on res_data/res_id.
REQ-008 The block SHALL have port res_ready, input, 1 bit: consumer takes the result.
REQ-009 The block SHALL have port res_data, output, 2*size+1 bits: A*B+C.
REQ-010 The block SHALL have port res_id, output, 1 bit: index of the requester that issued the result.

Function
REQ-011 The block SHALL share one two-stage multiply-add pipeline (stage 1: product register; stage 2: sum/output register) between the two requesters.
REQ-012 Accept: requester N's operation SHALL be accepted in a cycle where reqN_valid and reqN_ready are both 1 at the rising edge.
REQ-013 reqN_ready SHALL be combinational and SHALL be 1 only for the granted requester, and only when stage 1 can load, i.e. stage 1 is empty or advancing.
REQ-014 At most one requester SHALL be accepted per cycle; req0_ready and req1_ready SHALL never both be 1.
REQ-015 Arbitration SHALL be round-robin via a 1-bit last-served pointer: if both requesters are valid, grant goes to the requester not last served; if only one is valid, it is granted.
REQ-016 The pointer SHALL update only on an accept, to the accepted index; it SHALL be unchanged in idle and stall cycles.
REQ-017 Requesters SHALL hold operands stable while reqN_valid=1 and reqN_ready=0; the block SHALL sample operands only in the accept cycle.
REQ-018 Stage 1 SHALL capture A*B (2*size bits, unsigned), C and the requester id on accept.
REQ-019 Stage 2 SHALL compute product + C, zero-extended to 2*size+1 bits, with no truncation or overflow possible.
REQ-020 Advance condition SHALL be adv = !res_valid | res_ready; stage 1 SHALL move into stage 2 only when adv=1.
REQ-021 Latency SHALL be: accept at edge t results in res_valid=1 from edge t+2 when no stall occurs.
REQ-022 Throughput SHALL be one operation per cycle while res_ready=1.
REQ-023 Backpressure: with res_valid=1 and res_ready=0, res_data, res_id and res_valid SHALL hold unchanged; stage 1 SHALL hold if full; ready SHALL be 0 while stage 1 is full.
REQ-024 An empty stage 1 SHALL still accept a new operation during an output stall, giving at most two operations in flight.
REQ-025 res_valid SHALL drop after the res_ready handshake if stage 1 is empty.
REQ-026 Results SHALL leave in accept order; no operation SHALL be dropped or duplicated.
REQ-027 With both requesters valid and no stall, grants SHALL alternate 0,1,0,1... each cycle.

Reset
REQ-028 When rst=1 at a rising edge, stage 1 valid=0, res_valid=0, res_data=0, res_id=0 and pointer=1 (so req0 wins the first contention).
REQ-029 While rst=1, req0_ready and req1_ready SHALL be 0.
REQ-030 Reset mid-operation SHALL discard all in-flight operations with no result produced.
REQ-031 The cycle after rst deasserts, the block SHALL accept normally.

Verification
REQ-032 size=8, res_ready=1: req0 alone, A=255, B=255, C=255, accept at edge t -> res_valid at t+2, res_data=65280, res_id=0.
REQ-033 Both valid every cycle after reset with distinct operands -> grants 0,1,0,1; results in the same order with matching ids and values.
REQ-034 res_ready=0 for 5 cycles with both valid -> exactly two ops in flight, ready=0 thereafter, output stable; on release, results in order with none lost.
REQ-035 rst=1 with two ops in flight -> next cycle res_valid=0, res_data=0, and no stale result ever appears.
REQ-036 req1 valid held 3 cycles during a stall with changing values of no effect -> result uses the value at the accept edge.
REQ-037 A=0, B=200, C=0 -> res_data=0; A=1, B=1, C=255 -> res_data=256.

Source files
------------

// File: rtl/mac_sched.sv
// Two-requester multiply-add scheduler: round-robin arbitration into a shared
// two-stage pipeline (product register, then sum/output register) with backpressure.
module mac_sched #(
    parameter int size = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [size-1:0]   req0_a,
    input  logic [size-1:0]   req0_b,
    input  logic [size-1:0]   req0_c,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [size-1:0]   req1_a,
    input  logic [size-1:0]   req1_b,
    input  logic [size-1:0]   req1_c,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*size:0]   res_data,
    output logic              res_id
);

    localparam int PW = 2 * size;
    localparam int RW = 2 * size + 1;

    logic              ptr_r;
    logic              s1_valid_r;
    logic              s1_id_r;
    logic [PW-1:0]     s1_prod_r;
    logic [size-1:0]   s1_c_r;
    logic              res_valid_r;
    logic              res_id_r;
    logic [RW-1:0]     res_data_r;

    logic              adv_s;
    logic              load_s;
    logic              grant_valid_s;
    logic              grant_id_s;
    logic              accept_s;
    logic [size-1:0]   op_a_s;
    logic [size-1:0]   op_b_s;
    logic [size-1:0]   op_c_s;

    // Stage 1 may load when it is empty or its content moves on this cycle.
    assign adv_s    = !res_valid_r || res_ready;
    assign load_s   = !s1_valid_r || adv_s;
    assign accept_s = req0_ready || req1_ready;

    // Round-robin arbitration: contention goes to the requester not served last.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        case ({req1_valid, req0_valid})
            2'b01: begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b0;
            end
            2'b10: begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b1;
            end
            2'b11: begin
                grant_valid_s = 1'b1;
                grant_id_s    = ~ptr_r;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_id_s    = 1'b0;
            end
        endcase
    end

    // Handshake outputs and operand selection for the granted requester.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        op_a_s     = req0_a;
        op_b_s     = req0_b;
        op_c_s     = req0_c;
        if (!rst && load_s && grant_valid_s) begin
            if (grant_id_s) begin
                req1_ready = 1'b1;
            end else begin
                req0_ready = 1'b1;
            end
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
        if (grant_id_s) begin
            op_a_s = req1_a;
            op_b_s = req1_b;
            op_c_s = req1_c;
        end else begin
            op_a_s = req0_a;
            op_b_s = req0_b;
            op_c_s = req0_c;
        end
    end

    // Last-served pointer; resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b1;
        end else if (accept_s) begin
            ptr_r <= grant_id_s;
        end
    end

    // Stage 1: product, addend and issuing id, sampled only on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_id_r    <= 1'b0;
            s1_prod_r  <= {PW{1'b0}};
            s1_c_r     <= {size{1'b0}};
        end else if (load_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_id_r   <= grant_id_s;
                s1_prod_r <= PW'(op_a_s) * PW'(op_b_s);
                s1_c_r    <= op_c_s;
            end
        end
    end

    // Stage 2: the extra result bit absorbs the carry of product + C.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r <= 1'b0;
            res_id_r    <= 1'b0;
            res_data_r  <= {RW{1'b0}};
        end else if (adv_s) begin
            res_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                res_id_r   <= s1_id_r;
                res_data_r <= RW'(s1_prod_r) + RW'(s1_c_r);
            end
        end
    end

    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_id    = res_id_r;

endmodule

// File: tb/tb_mac_sched.sv
// Directed bench for mac_sched: arbitration, latency, backpressure, reset flush
// and operand corner cases, with an in-order scoreboard on the result port.
module tb_mac_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0]  req0_a, req0_b, req0_c, req1_a, req1_b, req1_c;
    logic        res_valid, res_ready, res_id;
    logic [16:0] res_data;

    int tests_run = 0;
    int fails     = 0;
    int n_out     = 0;

    typedef struct packed {
        logic [16:0] data;
        logic        id;
    } exp_t;
    exp_t sb[$];

    mac_sched #(.size(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mac(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return 17'(a) * 17'(b) + 17'(c);
    endfunction

    // Inputs change only just after a rising edge, so the falling edge sees the
    // values that the next rising edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (res_valid && res_ready) begin
                tests_run++;
                n_out++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected: got data=%0d id=%0d, required no result", res_data, res_id);
                    fails++;
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (res_data !== e.data || res_id !== e.id) begin
                        $display("FAIL sb_result: got data=%0d id=%0d, required data=%0d id=%0d",
                                 res_data, res_id, e.data, e.id);
                        fails++;
                    end
                end
            end
            if (req0_valid && req0_ready) sb.push_back({mac(req0_a, req0_b, req0_c), 1'b0});
            if (req1_valid && req1_ready) sb.push_back({mac(req1_a, req1_b, req1_c), 1'b1});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_ops0(input int k);
        req0_a = 8'(k * 3 + 1);
        req0_b = 8'(k * 5 + 2);
        req0_c = 8'(k + 7);
    endtask

    task automatic set_ops1(input int k);
        req1_a = 8'(200 - k);
        req1_b = 8'(100 + k);
        req1_c = 8'd50;
    endtask

    task automatic drain(input string name, input int expect_n, input int start_n);
        for (int j = 0; j < 20 && sb.size() != 0; j++) tick();
        tests_run++;
        if (sb.size() != 0 || (n_out - start_n) != expect_n) begin
            $display("FAIL %s_drain: got %0d results with %0d pending, required %0d results with 0 pending",
                     name, n_out - start_n, sb.size(), expect_n);
            fails++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        res_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        set_ops0(0);
        set_ops1(0);
        tick();
        tick();
        tests_run++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            $display("FAIL reset_ready: got %b%b, required 00", req1_ready, req0_ready);
            fails++;
        end
        tests_run++;
        if (res_valid !== 1'b0 || res_data !== 17'd0 || res_id !== 1'b0) begin
            $display("FAIL reset_outputs: got v=%b d=%0d id=%b, required v=0 d=0 id=0", res_valid, res_data, res_id);
            fails++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        res_ready = 1'b1;
        req0_a = 8'd255; req0_b = 8'd255; req0_c = 8'd255;
        req0_valid = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            $display("FAIL single_ready: got %b%b, required 01", req1_ready, req0_ready);
            fails++;
        end
        tick();
        req0_valid = 1'b0;
        tests_run++;
        if (res_valid !== 1'b0) begin
            $display("FAIL single_early: got res_valid=%b, required 0", res_valid);
            fails++;
        end
        tick();
        tests_run++;
        if (res_valid !== 1'b1 || res_data !== 17'd65280 || res_id !== 1'b0) begin
            $display("FAIL single_result: got v=%b d=%0d id=%b, required v=1 d=65280 id=0", res_valid, res_data, res_id);
            fails++;
        end
        tick();
        tests_run++;
        if (res_valid !== 1'b0) begin
            $display("FAIL single_drop: got res_valid=%b, required 0", res_valid);
            fails++;
        end
    endtask

    task automatic test_corner();
        int start_n;
        do_reset();
        start_n = n_out;
        res_ready = 1'b1;
        req0_a = 8'd0; req0_b = 8'd200; req0_c = 8'd0;
        req0_valid = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1) begin
            $display("FAIL corner_after_reset: got req0_ready=%b, required 1", req0_ready);
            fails++;
        end
        tick();
        req0_a = 8'd1; req0_b = 8'd1; req0_c = 8'd255;
        tick();
        req0_valid = 1'b0;
        tests_run++;
        if (res_valid !== 1'b1 || res_data !== 17'd0) begin
            $display("FAIL corner_zero: got v=%b d=%0d, required v=1 d=0", res_valid, res_data);
            fails++;
        end
        tick();
        tests_run++;
        if (res_valid !== 1'b1 || res_data !== 17'd256 || res_id !== 1'b0) begin
            $display("FAIL corner_carry: got v=%b d=%0d id=%b, required v=1 d=256 id=0", res_valid, res_data, res_id);
            fails++;
        end
        drain("corner", 2, start_n);
    endtask

    task automatic test_back_to_back();
        int k0, k1, start_n;
        logic exp_g;
        do_reset();
        start_n = n_out;
        res_ready = 1'b1;
        k0 = 0;
        k1 = 0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_ops0(k0);
            set_ops1(k1);
            exp_g = 1'(i % 2);
            #1;
            tests_run++;
            if (req0_ready !== ~exp_g || req1_ready !== exp_g) begin
                $display("FAIL b2b_grant%0d: got ready1/0=%b%b, required grant %0d", i, req1_ready, req0_ready, exp_g);
                fails++;
            end
            tick();
            if (exp_g) k1++; else k0++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain("b2b", 6, start_n);
    endtask

    task automatic test_backpressure();
        int start_n;
        logic [16:0] held;
        do_reset();
        start_n = n_out;
        res_ready = 1'b0;
        set_ops0(3);
        set_ops1(4);
        held = mac(req0_a, req0_b, req0_c);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        set_ops0(5);
        tick();
        set_ops1(6);
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                $display("FAIL bp_ready%0d: got %b%b, required 00", i, req1_ready, req0_ready);
                fails++;
            end
            tests_run++;
            if (res_valid !== 1'b1 || res_data !== held || res_id !== 1'b0) begin
                $display("FAIL bp_hold%0d: got v=%b d=%0d id=%b, required v=1 d=%0d id=0", i, res_valid, res_data, res_id, held);
                fails++;
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        drain("bp", 2, start_n);
    endtask

    task automatic test_hold();
        int start_n;
        do_reset();
        start_n = n_out;
        res_ready = 1'b0;
        req0_a = 8'd10; req0_b = 8'd20; req0_c = 8'd30;
        req0_valid = 1'b1;
        tick();
        req0_a = 8'd40; req0_b = 8'd50; req0_c = 8'd60;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            req1_a = 8'(j * 17 + 3);
            req1_b = 8'(j * 29 + 5);
            req1_c = 8'(j + 100);
            #1;
            tests_run++;
            if (req1_ready !== 1'b0) begin
                $display("FAIL hold_ready%0d: got req1_ready=%b, required 0", j, req1_ready);
                fails++;
            end
            tick();
        end
        req1_a = 8'd7; req1_b = 8'd9; req1_c = 8'd11;
        res_ready = 1'b1;
        #1;
        tests_run++;
        if (req1_ready !== 1'b1) begin
            $display("FAIL hold_accept: got req1_ready=%b, required 1", req1_ready);
            fails++;
        end
        tick();
        req1_valid = 1'b0;
        tick();
        tests_run++;
        if (res_valid !== 1'b1 || res_data !== 17'd74 || res_id !== 1'b1) begin
            $display("FAIL hold_value: got v=%b d=%0d id=%b, required v=1 d=74 id=1", res_valid, res_data, res_id);
            fails++;
        end
        drain("hold", 3, start_n);
    endtask

    task automatic test_reset_midflight();
        do_reset();
        res_ready = 1'b0;
        set_ops0(9);
        req0_valid = 1'b1;
        tick();
        set_ops0(10);
        tick();
        rst = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b0) begin
            $display("FAIL midrst_ready: got req0_ready=%b, required 0", req0_ready);
            fails++;
        end
        tick();
        tests_run++;
        if (res_valid !== 1'b0 || res_data !== 17'd0) begin
            $display("FAIL midrst_flush: got v=%b d=%0d, required v=0 d=0", res_valid, res_data);
            fails++;
        end
        rst = 1'b0;
        req0_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (res_valid !== 1'b0) begin
                $display("FAIL midrst_stale%0d: got res_valid=%b, required 0", i, res_valid);
                fails++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        res_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        set_ops0(0);
        set_ops1(0);
        tick();
        test_reset();
        test_single();
        test_corner();
        test_back_to_back();
        test_backpressure();
        test_hold();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
